// File: rtl/l2_cache_update_queued_stage_pkg.sv
// Shared defines for the L2 update stage: packet type encodings, line geometry and
// the request-to-response type mapping.
package l2_cache_update_queued_stage_pkg;

    localparam int CACHE_LINE_BYTES = 64;
    localparam int L2_ID_WIDTH      = 4;
    localparam int L2_ADDR_WIDTH    = 26;

    typedef enum logic [2:0] {
        REQ_LOAD        = 3'd0,
        REQ_STORE       = 3'd1,
        REQ_FLUSH       = 3'd2,
        REQ_DINVALIDATE = 3'd3,
        REQ_IINVALIDATE = 3'd4,
        REQ_LOAD_SYNC   = 3'd5,
        REQ_STORE_SYNC  = 3'd6
    } l2req_packet_type_t;

    typedef enum logic [2:0] {
        RSP_LOAD_ACK        = 3'd0,
        RSP_STORE_ACK       = 3'd1,
        RSP_FLUSH_ACK       = 3'd2,
        RSP_IINVALIDATE_ACK = 3'd3,
        RSP_DINVALIDATE_ACK = 3'd4
    } l2rsp_packet_type_t;

    typedef enum logic {
        CT_ICACHE = 1'b0,
        CT_DCACHE = 1'b1
    } l2_cache_type_t;

    // Unknown request encodings fall back to a load acknowledgement.
    function automatic l2rsp_packet_type_t response_type(input l2req_packet_type_t req);
        l2rsp_packet_type_t rsp;
        case (req)
            REQ_LOAD, REQ_LOAD_SYNC:   rsp = RSP_LOAD_ACK;
            REQ_STORE, REQ_STORE_SYNC: rsp = RSP_STORE_ACK;
            REQ_FLUSH:                 rsp = RSP_FLUSH_ACK;
            REQ_IINVALIDATE:           rsp = RSP_IINVALIDATE_ACK;
            REQ_DINVALIDATE:           rsp = RSP_DINVALIDATE_ACK;
            default:                   rsp = RSP_LOAD_ACK;
        endcase
        return rsp;
    endfunction

endpackage

// File: rtl/l2_cache_update_queued_stage_fifo.sv
// Synchronous FIFO with registered almost-full flag and sticky overflow flag.
// Entries written at an edge are readable combinationally in the following cycle.
module sync_fifo #(
    parameter int WIDTH                 = 32,
    parameter int SIZE                  = 8,
    parameter int ALMOST_FULL_THRESHOLD = SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enqueue_en,
    input  logic [WIDTH-1:0] value_i,
    input  logic             dequeue_en,
    output logic [WIDTH-1:0] value_o,
    output logic             empty,
    output logic             almost_full,
    output logic             overflow
);
    localparam int PTR_W = $clog2(SIZE);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q, overflow_d;
    logic             full, do_enq, do_deq;

    // A full queue still accepts a write when the head leaves in the same cycle.
    always_comb begin
        empty         = (count_q == '0);
        full          = (count_q == (PTR_W+1)'(SIZE));
        do_deq        = dequeue_en && !empty;
        do_enq        = enqueue_en && (!full || do_deq);
        rd_ptr_d      = rd_ptr_q + PTR_W'(do_deq);
        wr_ptr_d      = wr_ptr_q + PTR_W'(do_enq);
        count_d       = count_q + (PTR_W+1)'(do_enq) - (PTR_W+1)'(do_deq);
        almost_full_d = (count_d >= (PTR_W+1)'(ALMOST_FULL_THRESHOLD));
        overflow_d    = overflow_q || (enqueue_en && full && !do_deq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_q[wr_ptr_q] <= value_i;
        end
    end

    assign value_o     = mem_q[rd_ptr_q];
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(enqueue_en && full && !do_deq))
                else $warning("sync_fifo: entry dropped on a full queue");
        end
    end
`endif

endmodule

// File: rtl/l2_cache_update_queued_stage.sv
// L2 update stage: merges store bytes into the line written back to the data array and
// queues one response per finished request for the response interface.
module l2_cache_update_queued_stage
    import l2_cache_update_queued_stage_pkg::*;
#(
    parameter int LINE_BYTES     = CACHE_LINE_BYTES,
    parameter int INDEX_WIDTH    = 10,
    parameter int CORE_ID_WIDTH  = 2,
    parameter int RSP_FIFO_DEPTH = 8,
    parameter int STALL_SLACK    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       l2r_request_valid,
    input  l2req_packet_type_t         l2r_packet_type,
    input  logic [CORE_ID_WIDTH-1:0]   l2r_core,
    input  logic [L2_ID_WIDTH-1:0]     l2r_id,
    input  l2_cache_type_t             l2r_cache_type,
    input  logic [L2_ADDR_WIDTH-1:0]   l2r_address,
    input  logic [LINE_BYTES-1:0]      l2r_store_mask,
    input  logic [LINE_BYTES*8-1:0]    l2r_store_data,
    input  logic [LINE_BYTES*8-1:0]    l2r_data,
    input  logic [LINE_BYTES*8-1:0]    l2r_data_from_memory,
    input  logic                       l2r_cache_hit,
    input  logic [INDEX_WIDTH-1:0]     l2r_hit_cache_idx,
    input  logic                       l2r_is_l2_fill,
    input  logic                       l2r_is_restarted_flush,
    input  logic                       l2r_store_sync_success,
    input  logic                       l2r_needs_writeback,
    output logic                       l2u_write_en,
    output logic [INDEX_WIDTH-1:0]     l2u_write_addr,
    output logic [LINE_BYTES*8-1:0]    l2u_write_data,
    output logic                       l2_response_valid,
    input  logic                       l2_response_ready,
    output logic                       l2_response_status,
    output logic [CORE_ID_WIDTH-1:0]   l2_response_core,
    output logic [L2_ID_WIDTH-1:0]     l2_response_id,
    output l2rsp_packet_type_t         l2_response_packet_type,
    output l2_cache_type_t             l2_response_cache_type,
    output logic [L2_ADDR_WIDTH-1:0]   l2_response_address,
    output logic [LINE_BYTES*8-1:0]    l2_response_data,
    output logic                       l2u_stall,
    output logic                       l2u_overflow
);
    localparam int DATA_WIDTH = LINE_BYTES * 8;

    typedef struct packed {
        logic                     status;
        logic [CORE_ID_WIDTH-1:0] core;
        logic [L2_ID_WIDTH-1:0]   id;
        l2rsp_packet_type_t       packet_type;
        l2_cache_type_t           cache_type;
        logic [L2_ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    data;
    } rsp_entry_t;

    logic [DATA_WIDTH-1:0] source_data;
    logic                  is_store, update, flush_complete, enqueue, fifo_empty;
    rsp_entry_t            new_entry, head_entry;

    // A flush only answers once no writeback is pending for the line.
    always_comb begin
        source_data    = l2r_is_l2_fill ? l2r_data_from_memory : l2r_data;
        is_store       = (l2r_packet_type == REQ_STORE) || (l2r_packet_type == REQ_STORE_SYNC);
        update         = (l2r_packet_type == REQ_STORE)
                      || ((l2r_packet_type == REQ_STORE_SYNC) && l2r_store_sync_success);
        for (int b = 0; b < LINE_BYTES; b++) begin
            l2u_write_data[b*8 +: 8] = (l2r_store_mask[b] && update)
                                     ? l2r_store_data[b*8 +: 8] : source_data[b*8 +: 8];
        end
        l2u_write_en   = l2r_request_valid && (l2r_is_l2_fill || (l2r_cache_hit && is_store));
        l2u_write_addr = l2r_hit_cache_idx;
        flush_complete = (l2r_packet_type == REQ_FLUSH)
                      && (l2r_is_restarted_flush || !l2r_cache_hit || !l2r_needs_writeback);
        enqueue        = l2r_request_valid
                      && ((l2r_cache_hit && (l2r_packet_type != REQ_FLUSH)) || l2r_is_l2_fill
                          || flush_complete || (l2r_packet_type == REQ_DINVALIDATE)
                          || (l2r_packet_type == REQ_IINVALIDATE));

        new_entry.status      = (l2r_packet_type == REQ_STORE_SYNC) ? l2r_store_sync_success : 1'b1;
        new_entry.core        = l2r_core;
        new_entry.id          = l2r_id;
        new_entry.packet_type = response_type(l2r_packet_type);
        new_entry.cache_type  = l2r_cache_type;
        new_entry.address     = l2r_address;
        new_entry.data        = l2u_write_data;
    end

    sync_fifo #(
        .WIDTH                 ($bits(rsp_entry_t)),
        .SIZE                  (RSP_FIFO_DEPTH),
        .ALMOST_FULL_THRESHOLD (RSP_FIFO_DEPTH - STALL_SLACK)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .enqueue_en  (enqueue),
        .value_i     (new_entry),
        .dequeue_en  (l2_response_ready),
        .value_o     (head_entry),
        .empty       (fifo_empty),
        .almost_full (l2u_stall),
        .overflow    (l2u_overflow)
    );

    assign l2_response_valid       = !fifo_empty;
    assign l2_response_status      = head_entry.status;
    assign l2_response_core        = head_entry.core;
    assign l2_response_id          = head_entry.id;
    assign l2_response_packet_type = head_entry.packet_type;
    assign l2_response_cache_type  = head_entry.cache_type;
    assign l2_response_address     = head_entry.address;
    assign l2_response_data        = head_entry.data;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && l2r_request_valid) begin
            assert (!l2r_is_restarted_flush || (l2r_packet_type == REQ_FLUSH))
                else $error("restarted flush flagged on a non-flush request");
            assert (!(l2r_is_restarted_flush && l2r_is_l2_fill))
                else $error("restarted flush combined with an L2 fill");
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache_update_queued_stage.sv
// Randomised self-checking bench for the L2 update stage, with a queue-based response model.
module tb_l2_cache_update_queued_stage;
    import l2_cache_update_queued_stage_pkg::*;

    localparam int LB    = 64;
    localparam int DW    = LB * 8;
    localparam int DEPTH = 8;
    localparam int SLACK = 3;

    typedef struct {
        logic               status;
        logic [1:0]         core;
        logic [3:0]         id;
        l2rsp_packet_type_t ptype;
        l2_cache_type_t     ctype;
        logic [25:0]        addr;
        logic [DW-1:0]      data;
    } exp_rsp_t;

    logic clk = 1'b0;
    logic reset;
    logic l2r_request_valid;
    l2req_packet_type_t l2r_packet_type;
    logic [1:0] l2r_core;
    logic [3:0] l2r_id;
    l2_cache_type_t l2r_cache_type;
    logic [25:0] l2r_address;
    logic [LB-1:0] l2r_store_mask;
    logic [DW-1:0] l2r_store_data, l2r_data, l2r_data_from_memory;
    logic l2r_cache_hit;
    logic [9:0] l2r_hit_cache_idx;
    logic l2r_is_l2_fill, l2r_is_restarted_flush, l2r_store_sync_success, l2r_needs_writeback;
    logic l2u_write_en;
    logic [9:0] l2u_write_addr;
    logic [DW-1:0] l2u_write_data;
    logic l2_response_valid, l2_response_ready, l2_response_status;
    logic [1:0] l2_response_core;
    logic [3:0] l2_response_id;
    l2rsp_packet_type_t l2_response_packet_type;
    l2_cache_type_t l2_response_cache_type;
    logic [25:0] l2_response_address;
    logic [DW-1:0] l2_response_data;
    logic l2u_stall, l2u_overflow;

    exp_rsp_t exp_q[$];
    logic exp_overflow = 1'b0;
    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    l2_cache_update_queued_stage #(
        .LINE_BYTES(LB), .INDEX_WIDTH(10), .CORE_ID_WIDTH(2),
        .RSP_FIFO_DEPTH(DEPTH), .STALL_SLACK(SLACK)
    ) dut (
        .clk(clk), .reset(reset),
        .l2r_request_valid(l2r_request_valid), .l2r_packet_type(l2r_packet_type),
        .l2r_core(l2r_core), .l2r_id(l2r_id), .l2r_cache_type(l2r_cache_type),
        .l2r_address(l2r_address), .l2r_store_mask(l2r_store_mask),
        .l2r_store_data(l2r_store_data), .l2r_data(l2r_data),
        .l2r_data_from_memory(l2r_data_from_memory), .l2r_cache_hit(l2r_cache_hit),
        .l2r_hit_cache_idx(l2r_hit_cache_idx), .l2r_is_l2_fill(l2r_is_l2_fill),
        .l2r_is_restarted_flush(l2r_is_restarted_flush),
        .l2r_store_sync_success(l2r_store_sync_success),
        .l2r_needs_writeback(l2r_needs_writeback),
        .l2u_write_en(l2u_write_en), .l2u_write_addr(l2u_write_addr),
        .l2u_write_data(l2u_write_data),
        .l2_response_valid(l2_response_valid), .l2_response_ready(l2_response_ready),
        .l2_response_status(l2_response_status), .l2_response_core(l2_response_core),
        .l2_response_id(l2_response_id), .l2_response_packet_type(l2_response_packet_type),
        .l2_response_cache_type(l2_response_cache_type),
        .l2_response_address(l2_response_address), .l2_response_data(l2_response_data),
        .l2u_stall(l2u_stall), .l2u_overflow(l2u_overflow)
    );

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference rules, written straight from the behavioural description.
    function automatic logic [DW-1:0] model_write_data();
        logic [DW-1:0] src, res;
        logic upd;
        src = l2r_is_l2_fill ? l2r_data_from_memory : l2r_data;
        upd = (l2r_packet_type == REQ_STORE)
           || (l2r_packet_type == REQ_STORE_SYNC && l2r_store_sync_success);
        res = src;
        for (int b = 0; b < LB; b++)
            if (upd && l2r_store_mask[b]) res[b*8 +: 8] = l2r_store_data[b*8 +: 8];
        return res;
    endfunction

    function automatic logic model_write_en();
        logic st;
        st = (l2r_packet_type == REQ_STORE) || (l2r_packet_type == REQ_STORE_SYNC);
        return l2r_request_valid && (l2r_is_l2_fill || (l2r_cache_hit && st));
    endfunction

    function automatic logic model_enqueue();
        logic fl, done;
        fl = (l2r_packet_type == REQ_FLUSH);
        done = fl && (l2r_is_restarted_flush || !l2r_cache_hit || !l2r_needs_writeback);
        if (!l2r_request_valid) return 1'b0;
        return (l2r_cache_hit && !fl) || l2r_is_l2_fill || done
            || l2r_packet_type == REQ_DINVALIDATE || l2r_packet_type == REQ_IINVALIDATE;
    endfunction

    function automatic l2rsp_packet_type_t model_rsp_type();
        if (l2r_packet_type == REQ_STORE || l2r_packet_type == REQ_STORE_SYNC) return RSP_STORE_ACK;
        if (l2r_packet_type == REQ_FLUSH) return RSP_FLUSH_ACK;
        if (l2r_packet_type == REQ_IINVALIDATE) return RSP_IINVALIDATE_ACK;
        if (l2r_packet_type == REQ_DINVALIDATE) return RSP_DINVALIDATE_ACK;
        return RSP_LOAD_ACK;
    endfunction

    task automatic set_idle();
        l2r_request_valid = 1'b0;
        l2r_packet_type = REQ_LOAD;
        l2r_core = '0; l2r_id = '0; l2r_cache_type = CT_DCACHE; l2r_address = '0;
        l2r_store_mask = '0; l2r_store_data = '0; l2r_data = '0; l2r_data_from_memory = '0;
        l2r_cache_hit = 1'b0; l2r_hit_cache_idx = '0; l2r_is_l2_fill = 1'b0;
        l2r_is_restarted_flush = 1'b0; l2r_store_sync_success = 1'b0; l2r_needs_writeback = 1'b0;
    endtask

    task automatic drive_load(input logic [3:0] id, input logic [25:0] addr);
        set_idle();
        l2r_request_valid = 1'b1;
        l2r_packet_type = REQ_LOAD;
        l2r_cache_hit = 1'b1;
        l2r_id = id;
        l2r_address = addr;
        l2r_core = 2'($urandom);
        l2r_data = rand_line();
    endtask

    // Advances one clock edge and updates the model from the inputs seen at that edge.
    task automatic step();
        logic enq, deq;
        int size_before;
        exp_rsp_t e;
        enq = model_enqueue();
        size_before = exp_q.size();
        deq = (size_before != 0) && l2_response_ready;
        e.status = (l2r_packet_type == REQ_STORE_SYNC) ? l2r_store_sync_success : 1'b1;
        e.core = l2r_core; e.id = l2r_id; e.ptype = model_rsp_type();
        e.ctype = l2r_cache_type; e.addr = l2r_address; e.data = model_write_data();
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_overflow = 1'b0;
        end else begin
            if (deq) void'(exp_q.pop_front());
            if (enq) begin
                if (size_before == DEPTH && !deq) exp_overflow = 1'b1;
                else exp_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        l2_response_ready = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_compared++;
        if (l2_response_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", l2_response_valid); end
        n_compared++;
        if (l2u_stall !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", l2u_stall); end
        n_compared++;
        if (l2u_overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", l2u_overflow); end
    endtask

    task automatic test_store_hit();
        logic [DW-1:0] expd;
        logic [9:0] idx;
        expd = {LB{8'h55}};
        expd[31:0] = 32'hAAAA_AAAA;
        idx = 10'($urandom);
        set_idle();
        l2_response_ready = 1'b1;
        l2r_request_valid = 1'b1; l2r_packet_type = REQ_STORE; l2r_cache_hit = 1'b1;
        l2r_store_mask = 64'h0000_0000_0000_000F; l2r_store_data = {LB{8'hAA}};
        l2r_data = {LB{8'h55}}; l2r_hit_cache_idx = idx; l2r_id = 4'h3;
        #1;
        n_compared++;
        if (l2u_write_en !== 1'b1) begin n_mismatched++; $display("[TB] FAIL store_write_en: got %b expected 1", l2u_write_en); end
        n_compared++;
        if (l2u_write_addr !== idx) begin n_mismatched++; $display("[TB] FAIL store_write_addr: got %h expected %h", l2u_write_addr, idx); end
        n_compared++;
        if (l2u_write_data !== expd) begin n_mismatched++; $display("[TB] FAIL store_write_data: got %h expected %h", l2u_write_data, expd); end
        step();
        set_idle();
        n_compared++;
        if (l2_response_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL store_rsp_valid: got %b expected 1", l2_response_valid); end
        n_compared++;
        if (l2_response_packet_type !== RSP_STORE_ACK) begin n_mismatched++; $display("[TB] FAIL store_rsp_type: got %0d expected %0d", l2_response_packet_type, RSP_STORE_ACK); end
        n_compared++;
        if (l2_response_status !== 1'b1 || l2_response_data !== expd || l2_response_id !== 4'h3) begin
            n_mismatched++; $display("[TB] FAIL store_rsp_fields: got status %b id %h expected status 1 id 3", l2_response_status, l2_response_id);
        end
        step();
        n_compared++;
        if (l2_response_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL store_drain: got %b expected 0", l2_response_valid); end
    endtask

    task automatic test_store_sync_fail();
        logic [DW-1:0] line;
        line = rand_line();
        set_idle();
        l2r_request_valid = 1'b1; l2r_packet_type = REQ_STORE_SYNC; l2r_cache_hit = 1'b1;
        l2r_store_sync_success = 1'b0; l2r_store_mask = {$urandom, $urandom} | 64'h1;
        l2r_store_data = rand_line(); l2r_data = line;
        #1;
        n_compared++;
        if (l2u_write_data !== line || l2u_write_en !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL sync_write: got en %b data %h expected en 1 data %h", l2u_write_en, l2u_write_data, line);
        end
        step();
        set_idle();
        n_compared++;
        if (l2_response_valid !== 1'b1 || l2_response_packet_type !== RSP_STORE_ACK || l2_response_status !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL sync_rsp: got valid %b type %0d status %b expected 1 %0d 0", l2_response_valid, l2_response_packet_type, l2_response_status, RSP_STORE_ACK);
        end
        step();
    endtask

    task automatic test_flush_restart();
        set_idle();
        l2r_request_valid = 1'b1; l2r_packet_type = REQ_FLUSH; l2r_cache_hit = 1'b1;
        l2r_needs_writeback = 1'b1; l2r_address = 26'h12345;
        step();
        n_compared++;
        if (l2_response_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_first_pass: got %b expected 0", l2_response_valid); end
        l2r_is_restarted_flush = 1'b1;
        step();
        set_idle();
        n_compared++;
        if (l2_response_valid !== 1'b1 || l2_response_packet_type !== RSP_FLUSH_ACK || l2_response_address !== 26'h12345) begin
            n_mismatched++; $display("[TB] FAIL flush_second_pass: got valid %b type %0d expected 1 %0d", l2_response_valid, l2_response_packet_type, RSP_FLUSH_ACK);
        end
        step();
        n_compared++;
        if (l2_response_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_single_ack: got %b expected 0", l2_response_valid); end
    endtask

    task automatic test_backpressure();
        logic [25:0] addrs [DEPTH];
        l2_response_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            addrs[i] = 26'($urandom);
            drive_load(4'(i), addrs[i]);
            step();
            n_compared++;
            if (l2u_stall !== (i + 1 >= DEPTH - SLACK)) begin n_mismatched++; $display("[TB] FAIL bp_stall_%0d: got %b expected %b", i, l2u_stall, (i + 1 >= DEPTH - SLACK)); end
            n_compared++;
            if (l2_response_valid !== 1'b1 || l2_response_id !== 4'd0 || l2_response_address !== addrs[0] || l2u_overflow !== 1'b0) begin
                n_mismatched++; $display("[TB] FAIL bp_hold_%0d: got valid %b id %h ovf %b expected 1 0 0", i, l2_response_valid, l2_response_id, l2u_overflow);
            end
        end
        set_idle();
        l2_response_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_compared++;
            if (l2_response_valid !== 1'b1 || l2_response_id !== 4'(i) || l2_response_address !== addrs[i]) begin
                n_mismatched++; $display("[TB] FAIL bp_drain_%0d: got valid %b id %h expected 1 %h", i, l2_response_valid, l2_response_id, 4'(i));
            end
            step();
        end
        n_compared++;
        if (l2_response_valid !== 1'b0 || l2u_stall !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_empty: got valid %b stall %b expected 0 0", l2_response_valid, l2u_stall); end
    endtask

    task automatic test_full_simultaneous();
        l2_response_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_load(4'(i), 26'(i));
            step();
        end
        l2_response_ready = 1'b1;
        drive_load(4'd8, 26'd8);
        step();
        n_compared++;
        if (l2_response_id !== 4'd1 || l2u_stall !== 1'b1 || l2u_overflow !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL full_enq_deq: got head %h stall %b ovf %b expected 1 1 0", l2_response_id, l2u_stall, l2u_overflow);
        end
        l2_response_ready = 1'b0;
        drive_load(4'd9, 26'd9);
        step();
        n_compared++;
        if (l2u_overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_overflow: got %b expected 1", l2u_overflow); end
        set_idle();
        l2_response_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_compared++;
            if (l2_response_valid !== 1'b1 || l2_response_id !== 4'(i)) begin
                n_mismatched++; $display("[TB] FAIL full_drain_%0d: got valid %b id %h expected 1 %h", i, l2_response_valid, l2_response_id, 4'(i));
            end
            step();
        end
        n_compared++;
        if (l2_response_valid !== 1'b0 || l2u_overflow !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL full_dropped: got valid %b ovf %b expected 0 1", l2_response_valid, l2u_overflow);
        end
    endtask

    task automatic test_reset_midop();
        l2_response_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_load(4'(i), 26'(i));
            step();
        end
        n_compared++;
        if (l2_response_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midop_before: got %b expected 1", l2_response_valid); end
        set_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_compared++;
        if (l2_response_valid !== 1'b0 || l2u_stall !== 1'b0 || l2u_overflow !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL midop_reset: got valid %b stall %b ovf %b expected 0 0 0", l2_response_valid, l2u_stall, l2u_overflow);
        end
        l2_response_ready = 1'b1;
        step();
        n_compared++;
        if (l2_response_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midop_after: got %b expected 0", l2_response_valid); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            l2r_request_valid = ($urandom_range(0, 1) == 1);
            l2r_packet_type = l2req_packet_type_t'(3'($urandom_range(0, 7)));
            l2r_core = 2'($urandom); l2r_id = 4'($urandom); l2r_address = 26'($urandom);
            l2r_cache_type = l2_cache_type_t'(1'($urandom));
            l2r_store_mask = {$urandom, $urandom};
            l2r_store_data = rand_line(); l2r_data = rand_line(); l2r_data_from_memory = rand_line();
            l2r_cache_hit = 1'($urandom); l2r_hit_cache_idx = 10'($urandom);
            l2r_is_l2_fill = ($urandom_range(0, 5) == 0);
            l2r_is_restarted_flush = (l2r_packet_type == REQ_FLUSH && !l2r_is_l2_fill) ? 1'($urandom) : 1'b0;
            l2r_store_sync_success = 1'($urandom); l2r_needs_writeback = 1'($urandom);
            l2_response_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_compared++;
            if (l2u_write_en !== model_write_en() || l2u_write_addr !== l2r_hit_cache_idx) begin
                n_mismatched++; $display("[TB] FAIL rnd_write_en_%0d: got en %b addr %h expected %b %h", cyc, l2u_write_en, l2u_write_addr, model_write_en(), l2r_hit_cache_idx);
            end
            n_compared++;
            if (l2u_write_data !== model_write_data()) begin
                n_mismatched++; $display("[TB] FAIL rnd_write_data_%0d: got %h expected %h", cyc, l2u_write_data, model_write_data());
            end
            step();
            n_compared++;
            if (l2_response_valid !== (exp_q.size() != 0) || l2u_stall !== (exp_q.size() >= DEPTH - SLACK) || l2u_overflow !== exp_overflow) begin
                n_mismatched++; $display("[TB] FAIL rnd_status_%0d: got valid %b stall %b ovf %b expected occupancy %0d ovf %b", cyc, l2_response_valid, l2u_stall, l2u_overflow, exp_q.size(), exp_overflow);
            end
            if (exp_q.size() != 0) begin
                n_compared++;
                if (l2_response_status !== exp_q[0].status || l2_response_core !== exp_q[0].core
                    || l2_response_id !== exp_q[0].id || l2_response_packet_type !== exp_q[0].ptype
                    || l2_response_cache_type !== exp_q[0].ctype || l2_response_address !== exp_q[0].addr
                    || l2_response_data !== exp_q[0].data) begin
                    n_mismatched++; $display("[TB] FAIL rnd_head_%0d: got id %h type %0d status %b expected id %h type %0d status %b", cyc, l2_response_id, l2_response_packet_type, l2_response_status, exp_q[0].id, exp_q[0].ptype, exp_q[0].status);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        l2_response_ready = 1'b1;
        reset = 1'b1;
        test_reset();
        test_store_hit();
        test_store_sync_fail();
        test_flush_restart();
        test_backpressure();
        test_full_simultaneous();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/l2_cache_update_queued_stage.md
L2_CACHE_UPDATE_QUEUED_STAGE -- requirements
Module: l2_cache_update_queued_stage

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 64, meaning bytes per cache line; the data width is LINE_BYTES*8.
REQ-002 SHALL have parameter INDEX_WIDTH, default 10, meaning the width of the flat way*set line index.
REQ-003 SHALL have parameter CORE_ID_WIDTH, default 2, meaning the width of the requesting-core field.
REQ-004 SHALL have parameter RSP_FIFO_DEPTH, default 8, a power of two >=4, meaning the number of response queue entries.
REQ-005 SHALL have parameter STALL_SLACK, default 3, less than RSP_FIFO_DEPTH, meaning the upstream requests that may still be in flight after stall asserts.
REQ-006 SHALL have ports clk (in, 1, clock) and reset (in, 1); the block uses one clock and reset is synchronous and active-high.
REQ-007 SHALL have input ports from the read stage: l2r_request_valid 1; l2r_packet_type l2req_packet_type_t; l2r_core CORE_ID_WIDTH; l2r_id; l2r_cache_type; l2r_address; l2r_store_mask LINE_BYTES; l2r_store_data LINE_BYTES*8; l2r_data LINE_BYTES*8; l2r_data_from_memory LINE_BYTES*8; l2r_cache_hit 1; l2r_hit_cache_idx INDEX_WIDTH; l2r_is_l2_fill 1; l2r_is_restarted_flush 1; l2r_store_sync_success 1; l2r_needs_writeback 1.
REQ-008 SHALL have outputs to the data array: l2u_write_en 1; l2u_write_addr INDEX_WIDTH; l2u_write_data LINE_BYTES*8.
REQ-009 SHALL have the response handshake: l2_response_valid out 1; l2_response_ready in 1; l2_response out l2rsp fields (status, core, id, packet_type, cache_type, address, data).
REQ-010 SHALL have status outputs: l2u_stall out 1 (upstream must stop issuing); l2u_overflow out 1 (sticky error).

Function
REQ-011 Source data SHALL be l2r_data_from_memory when l2r_is_l2_fill, else l2r_data.
REQ-012 Update SHALL be true for STORE, or for STORE_SYNC with l2r_store_sync_success.
REQ-013 Each byte lane b of l2u_write_data SHALL take store data when store_mask[b]&&update, else the source byte.
REQ-014 l2u_write_en SHALL equal valid && (fill || (hit && packet type is STORE/STORE_SYNC)), combinationally, same cycle.
REQ-015 l2u_write_addr SHALL equal l2r_hit_cache_idx.
REQ-016 Response type mapping: LOAD/LOAD_SYNC->LOAD_ACK; STORE/STORE_SYNC->STORE_ACK; FLUSH->FLUSH_ACK; IINVALIDATE->IINVALIDATE_ACK; DINVALIDATE->DINVALIDATE_ACK; other->LOAD_ACK.
REQ-017 A flush is complete when it is FLUSH && (restarted_flush || !hit || !needs_writeback).
REQ-018 Enqueue SHALL occur when valid && ((hit && !FLUSH) || fill || completed flush || DINVALIDATE || IINVALIDATE).
REQ-019 Entry status SHALL be store_sync_success for STORE_SYNC, else 1; entry data SHALL be l2u_write_data.
REQ-020 Queue SHALL be FIFO; an entry enqueued at edge T SHALL be visible on l2_response with valid in the cycle after T (latency 1).
REQ-021 Dequeue SHALL occur on edge where valid && ready; l2_response SHALL hold stable while valid && !ready.
REQ-022 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged, including when full.
REQ-023 Enqueue while full without dequeue SHALL discard the new entry and set l2u_overflow until reset.
REQ-024 l2u_stall SHALL be registered, high when the next occupancy is >= RSP_FIFO_DEPTH-STALL_SLACK.
REQ-025 Pointers SHALL wrap modulo RSP_FIFO_DEPTH; occupancy SHALL be a $clog2(DEPTH)+1-bit counter.
REQ-026 Assertions (simulation) SHALL check: restarted_flush implies FLUSH; !(restarted_flush && fill); no overflow.

Reset
REQ-027 On reset, l2_response_valid, l2u_stall, l2u_overflow, occupancy and pointers SHALL be 0; queue contents are don't-care.
REQ-028 Reset mid-operation SHALL discard all queued responses; l2u_write_en SHALL remain combinational and need no reset.

Structure
REQ-029 l2req/l2rsp packet type enums and CACHE_LINE_BYTES default SHALL come from the shared defines package.
REQ-030 Queue SHALL be one sub-module, sync_fifo (parametrised WIDTH, SIZE, ALMOST_FULL_THRESHOLD).

Verification
REQ-031 STORE hit, mask 0x...000F, data 0xAA.., l2r_data 0x55.. -> write_en=1, bytes 0-3=0xAA, rest 0x55; STORE_ACK, status 1, next cycle.
REQ-032 STORE_SYNC hit with success=0 -> write_data equals l2r_data; STORE_ACK, status 0.
REQ-033 FLUSH hit with needs_writeback=1, then restarted flush -> no response on the first pass; one FLUSH_ACK on the second pass.
REQ-034 ready=0 with 8 enqueues (DEPTH 8, SLACK 3) -> stall high after the 5th; valid held; overflow stays 0; then ready=1 -> 8 responses drain in order.
REQ-035 Full queue, enqueue+dequeue in the same cycle -> occupancy stays 8; 9th enqueue without dequeue -> overflow=1, entry dropped.
REQ-036 Reset asserted with 4 entries queued -> next cycle valid=0, stall=0, overflow=0.
